// File: rtl/array_multiplier.sv
// Registered unsigned carry-save array multiplier: operand registers, an explicit
// HA/FA reduction array with a ripple-carry final row, and a product register.

module ha_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module fa_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);
endmodule

module array_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 ena,
  input  logic                 enb,
  output logic [2*WIDTH-1:0]   p
);

  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] p_r;
  logic [2*WIDTH-1:0] prod;

  // pp[i][j] has weight i+j; s_row[i][j] has weight i+j, c_row[i][j] has weight i+j+1.
  logic [WIDTH-1:0] pp    [WIDTH];
  logic [WIDTH-1:0] s_row [WIDTH];
  logic [WIDTH-1:0] c_row [1:WIDTH-1];
  logic [WIDTH-2:0] fc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      p_r <= '0;
    end else begin
      if (ena) a_r <= a;
      if (enb) b_r <= b;
      p_r <= prod;
    end
  end

  assign p = p_r;

  genvar gi, gj;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp_row
      for (gj = 0; gj < WIDTH; gj++) begin : g_pp_col
        assign pp[gi][gj] = a_r[gj] & b_r[gi];
      end
    end

    assign s_row[0] = pp[0];

    // Each row adds pp[i][j], the previous row's sum shifted down one, and the
    // previous row's carry; cells whose third input is known zero become HAs.
    for (gi = 1; gi < WIDTH; gi++) begin : g_row
      for (gj = 0; gj < WIDTH; gj++) begin : g_cell
        if (gi == 1 && gj < WIDTH-1) begin : g_ha_top
          ha_cell u_ha (
            .x(pp[gi][gj]),
            .y(s_row[gi-1][gj+1]),
            .s(s_row[gi][gj]),
            .c(c_row[gi][gj])
          );
        end else if (gi == 1) begin : g_pass
          assign s_row[gi][gj] = pp[gi][gj];
          assign c_row[gi][gj] = 1'b0;
        end else if (gj < WIDTH-1) begin : g_fa
          fa_cell u_fa (
            .x(pp[gi][gj]),
            .y(s_row[gi-1][gj+1]),
            .z(c_row[gi-1][gj]),
            .s(s_row[gi][gj]),
            .c(c_row[gi][gj])
          );
        end else begin : g_ha_edge
          ha_cell u_ha (
            .x(pp[gi][gj]),
            .y(c_row[gi-1][gj]),
            .s(s_row[gi][gj]),
            .c(c_row[gi][gj])
          );
        end
      end
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_low_bits
      assign prod[gi] = s_row[gi][0];
    end

    // Final ripple-carry row for weights WIDTH..2*WIDTH-1. The product never
    // exceeds 2*WIDTH bits, so the top position needs no carry out.
    for (gi = 0; gi < WIDTH; gi++) begin : g_final
      if (gi == 0) begin : g_ha
        ha_cell u_ha (
          .x(s_row[WIDTH-1][1]),
          .y(c_row[WIDTH-1][0]),
          .s(prod[WIDTH]),
          .c(fc[0])
        );
      end else if (gi < WIDTH-1) begin : g_fa
        fa_cell u_fa (
          .x(s_row[WIDTH-1][gi+1]),
          .y(c_row[WIDTH-1][gi]),
          .z(fc[gi-1]),
          .s(prod[WIDTH+gi]),
          .c(fc[gi])
        );
      end else begin : g_top
        assign prod[2*WIDTH-1] = c_row[WIDTH-1][gi] ^ fc[gi-1];
      end
    end
  endgenerate

endmodule

// File: tb/tb_array_multiplier.sv
// Directed and randomized checks of array_multiplier against an arithmetic
// model of the two-stage operand/product pipeline.

module tb_array_multiplier;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           ena = 1'b0;
  logic           enb = 1'b0;
  logic [2*W-1:0] p;

  int checks = 0;
  int errors = 0;

  int unsigned ma = 0;
  int unsigned mb = 0;
  int unsigned mexp = 0;

  array_multiplier #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .b(b),
    .ena(ena),
    .enb(enb),
    .p(p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] exp);
    checks++;
    assert (p === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, p, exp);
    end
  endtask

  // Drive on the falling edge, advance the model at the rising edge, sample 1ns later.
  task automatic step(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ea, input logic eb, input string tag);
    @(negedge clk);
    a = av; b = bv; ena = ea; enb = eb;
    @(posedge clk);
    if (rst_n) begin
      mexp = ma * mb;
      if (ea) ma = av;
      if (eb) mb = bv;
    end
    #1 check(tag, mexp[2*W-1:0]);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    ena = 1'b0; enb = 1'b0;
    #2 rst_n = 1'b0;
    ma = 0; mb = 0; mexp = 0;
    #1 check("rst_async", '0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Reset, then idle
    #2 rst_n = 1'b0;
    #1 check("reset", '0);
    step(8'd77, 8'd99, 1'b1, 1'b1, "rst_ignore_en");
    step(8'd77, 8'd99, 1'b1, 1'b1, "rst_ignore_en2");
    @(negedge clk);
    ena = 1'b0; enb = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(8'd0, 8'd0, 1'b0, 1'b0, "idle");

    // 5*3, then hold
    step(8'd5, 8'd3, 1'b1, 1'b1, "cap_5x3");
    step(8'd0, 8'd0, 1'b0, 1'b0, "lat_5x3");
    check("p15", 16'd15);
    for (int i = 0; i < 3; i++) step(8'd1, 8'd1, 1'b0, 1'b0, "hold_15");
    check("p15_hold", 16'd15);

    // Enables held high: 10*10 then 255*2
    step(8'd10, 8'd10, 1'b1, 1'b1, "cap_10x10");
    step(8'd10, 8'd10, 1'b1, 1'b1, "lat_10x10");
    check("p100", 16'd100);
    step(8'd255, 8'd2, 1'b1, 1'b1, "cap_255x2");
    step(8'd255, 8'd2, 1'b1, 1'b1, "lat_255x2");
    check("p510", 16'd510);

    // Maximum product
    step(8'd255, 8'd255, 1'b1, 1'b1, "cap_max");
    step(8'd255, 8'd255, 1'b1, 1'b1, "lat_max");
    check("p65025", 16'd65025);

    // Independent enables: b_r held at 9
    step(8'd7, 8'd9, 1'b1, 1'b1, "cap_7x9");
    step(8'd0, 8'd0, 1'b0, 1'b0, "lat_7x9");
    check("p63", 16'd63);
    step(8'd4, 8'd200, 1'b1, 1'b0, "cap_a_only");
    step(8'd0, 8'd0, 1'b0, 1'b0, "lat_a_only");
    check("p36", 16'd36);
    step(8'd11, 8'd6, 1'b0, 1'b1, "cap_b_only");
    step(8'd0, 8'd0, 1'b0, 1'b0, "lat_b_only");
    check("p24", 16'd24);

    // Mid-operation reset
    step(8'd200, 8'd200, 1'b1, 1'b1, "cap_200x200");
    step(8'd0, 8'd0, 1'b0, 1'b0, "lat_200x200");
    check("p40000", 16'd40000);
    step(8'd13, 8'd17, 1'b1, 1'b1, "cap_pending");
    @(negedge clk);
    #2 rst_n = 1'b0;
    ma = 0; mb = 0; mexp = 0;
    #1 check("mid_rst_async", '0);
    step(8'd9, 8'd9, 1'b1, 1'b1, "mid_rst_ignore");
    @(negedge clk);
    ena = 1'b0; enb = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(8'd9, 8'd9, 1'b0, 1'b0, "post_rst_idle");
    step(8'd3, 8'd4, 1'b1, 1'b1, "post_rst_cap");
    check("post_rst_still0", '0);
    step(8'd0, 8'd0, 1'b0, 1'b0, "post_rst_lat");
    check("p12", 16'd12);

    // Randomized traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) reset_pulse();
      step(W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
